// File: rtl/mor1kx_spr_initiator.sv
// SPR bus initiator: accepts one mtspr/mfspr request at a time, strobes the SPR
// bus until the addressed unit acks or the access times out, then responds once.
module mor1kx_spr_initiator #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [15:0] req_addr_i,
  input  logic [31:0] req_dat_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        spr_access_o,
  output logic        spr_we_o,
  output logic [15:0] spr_addr_o,
  output logic [31:0] spr_dat_o,
  input  logic        spr_bus_ack_i,
  input  logic [31:0] spr_dat_i
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state;
  logic [7:0] cnt;

  // Every output is a register, so the bus strobe and the response pulse are
  // glitch-free and the whole block clears the instant rst falls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      req_ready_o  <= 1'b1;
      spr_access_o <= 1'b0;
      spr_we_o     <= 1'b0;
      spr_addr_o   <= '0;
      spr_dat_o    <= '0;
      rsp_valid_o  <= 1'b0;
      rsp_dat_o    <= '0;
      rsp_err_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            spr_we_o     <= req_we_i;
            spr_addr_o   <= req_addr_i;
            spr_dat_o    <= req_we_i ? req_dat_i : 32'h0;
            cnt          <= '0;
            spr_access_o <= 1'b1;
            req_ready_o  <= 1'b0;
            state        <= ACCESS;
          end
        end

        ACCESS: begin
          // An ack on the final allowed cycle still counts as a success.
          if (spr_bus_ack_i) begin
            rsp_dat_o    <= spr_we_o ? 32'h0 : spr_dat_i;
            rsp_err_o    <= 1'b0;
            rsp_valid_o  <= 1'b1;
            spr_access_o <= 1'b0;
            spr_we_o     <= 1'b0;
            state        <= RESP;
          end else if (cnt == CNT_LAST) begin
            rsp_dat_o    <= 32'h0;
            rsp_err_o    <= 1'b1;
            rsp_valid_o  <= 1'b1;
            spr_access_o <= 1'b0;
            spr_we_o     <= 1'b0;
            state        <= RESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        RESP: begin
          rsp_valid_o <= 1'b0;
          req_ready_o <= 1'b1;
          state       <= IDLE;
        end

        default: begin
          spr_access_o <= 1'b0;
          spr_we_o     <= 1'b0;
          rsp_valid_o  <= 1'b0;
          req_ready_o  <= 1'b1;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule
